// File: rtl/el2_pmu_halt_initiator_if.sv
// el2_pmu_halt_initiator_if: groups the software-command, core-handshake and status signals of the PMU halt initiator.
// Signals:
//   sw_halt_req / sw_run_req      single-cycle software commands
//   cpu_halt_ack / cpu_run_ack    core acknowledges
//   cpu_halt_status               core reports halted
//   cpu_debug_mode                core is in debug mode
//   cpu_halt_req / cpu_run_req    requests to the core
//   busy / halted                 initiator status
//   cmd_done / cmd_rejected       one-cycle result pulses
//   timeout_err                   sticky timeout flag
// Modports: master drives commands and core responses, slave is the initiator.
interface el2_pmu_halt_initiator_if;
    logic sw_halt_req;
    logic sw_run_req;
    logic cpu_halt_ack;
    logic cpu_run_ack;
    logic cpu_halt_status;
    logic cpu_debug_mode;
    logic cpu_halt_req;
    logic cpu_run_req;
    logic busy;
    logic halted;
    logic cmd_done;
    logic cmd_rejected;
    logic timeout_err;

    modport master (
        output sw_halt_req, sw_run_req, cpu_halt_ack, cpu_run_ack, cpu_halt_status, cpu_debug_mode,
        input  cpu_halt_req, cpu_run_req, busy, halted, cmd_done, cmd_rejected, timeout_err
    );

    modport slave (
        input  sw_halt_req, sw_run_req, cpu_halt_ack, cpu_run_ack, cpu_halt_status, cpu_debug_mode,
        output cpu_halt_req, cpu_run_req, busy, halted, cmd_done, cmd_rejected, timeout_err
    );
endinterface

// File: rtl/el2_pmu_halt_initiator.sv
// el2_pmu_halt_initiator: drives the core halt/run four-phase handshakes on behalf of power-management software.
// Ports:
//   clk    core clock, all state on the rising edge
//   rst_l  asynchronous active-low reset
//   bus    el2_pmu_halt_initiator_if.slave (commands, core handshake, status outputs)
// Parameter TIMEOUT_CYCLES (2..65535) bounds the wait for an ack when
// EL2_PMU_HALT_TIMEOUT_EN is defined; otherwise requests wait forever and timeout_err is 0.
// Every output is a flop loaded from a value derived from the next state.
module el2_pmu_halt_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic rst_l,
    el2_pmu_halt_initiator_if.slave bus
);
    typedef enum logic [2:0] {IDLE, HALT_REQ, HALT_ACKLOW, HALTED, RUN_REQ, RUN_ACKLOW} state_t;

    state_t state_q, state_d;
    logic halt_ok, run_ok, tmo;
    logic cpu_halt_req_q, cpu_halt_req_d;
    logic cpu_run_req_q, cpu_run_req_d;
    logic busy_q, busy_d;
    logic halted_q, halted_d;
    logic cmd_done_q, cmd_done_d;
    logic cmd_rejected_q, cmd_rejected_d;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 2..65535");
    end

    always_comb begin
        halt_ok = bus.sw_halt_req && state_q == IDLE && !bus.cpu_debug_mode;
        run_ok = bus.sw_run_req && state_q == HALTED;
        state_d = state_q;
        case (state_q)
            IDLE: state_d = halt_ok ? HALT_REQ : IDLE;
            HALT_REQ: state_d = bus.cpu_halt_ack ? HALT_ACKLOW : (tmo ? IDLE : HALT_REQ);
            HALT_ACKLOW: state_d = bus.cpu_halt_ack ? HALT_ACKLOW : HALTED;
            // An explicit resume wins over a self-wake seen in the same cycle.
            HALTED: state_d = run_ok ? RUN_REQ : (bus.cpu_halt_status ? HALTED : IDLE);
            RUN_REQ: state_d = bus.cpu_run_ack ? RUN_ACKLOW : (tmo ? HALTED : RUN_REQ);
            RUN_ACKLOW: state_d = bus.cpu_run_ack ? RUN_ACKLOW : IDLE;
            default: state_d = IDLE;
        endcase
        cpu_halt_req_d = state_d == HALT_REQ;
        cpu_run_req_d = state_d == RUN_REQ;
        busy_d = !(state_d == IDLE || state_d == HALTED);
        halted_d = state_d == HALTED;
        cmd_done_d = (state_q == HALT_ACKLOW && state_d == HALTED) || (state_q == RUN_ACKLOW && state_d == IDLE);
        // Simultaneous halt and run pulses collapse into one rejection pulse.
        cmd_rejected_d = (bus.sw_halt_req && !halt_ok) || (bus.sw_run_req && !run_ok);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= IDLE;
            cpu_halt_req_q <= 1'b0;
            cpu_run_req_q <= 1'b0;
            busy_q <= 1'b0;
            halted_q <= 1'b0;
            cmd_done_q <= 1'b0;
            cmd_rejected_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cpu_halt_req_q <= cpu_halt_req_d;
            cpu_run_req_q <= cpu_run_req_d;
            busy_q <= busy_d;
            halted_q <= halted_d;
            cmd_done_q <= cmd_done_d;
            cmd_rejected_q <= cmd_rejected_d;
        end
    end

`ifdef EL2_PMU_HALT_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic timeout_err_q, timeout_err_d;
    logic tmo_fire, entering_req;

    assign tmo = cnt_q == 16'(TIMEOUT_CYCLES - 1);

    always_comb begin
        entering_req = (state_d == HALT_REQ || state_d == RUN_REQ) && state_d != state_q;
        // Ack has priority over expiry in the same cycle.
        tmo_fire = tmo && ((state_q == HALT_REQ && !bus.cpu_halt_ack) || (state_q == RUN_REQ && !bus.cpu_run_ack));
        cnt_d = ((state_q == HALT_REQ || state_q == RUN_REQ) && state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
        timeout_err_d = entering_req ? 1'b0 : (timeout_err_q || tmo_fire);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= 16'd0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign tmo = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.cpu_halt_req = cpu_halt_req_q;
    assign bus.cpu_run_req = cpu_run_req_q;
    assign bus.busy = busy_q;
    assign bus.halted = halted_q;
    assign bus.cmd_done = cmd_done_q;
    assign bus.cmd_rejected = cmd_rejected_q;
endmodule

// File: tb/tb_el2_pmu_halt_initiator.sv
// tb_el2_pmu_halt_initiator: directed self-checking bench for el2_pmu_halt_initiator.
// Stimulus vector s = {sw_halt_req, sw_run_req, cpu_halt_ack, cpu_run_ack, cpu_halt_status, cpu_debug_mode}
// is applied before a rising edge; the expected vector
// e = {cpu_halt_req, cpu_run_req, busy, halted, cmd_done, cmd_rejected, timeout_err} is the registered result after it.
// Honours EL2_PMU_HALT_TIMEOUT_EN (TIMEOUT_CYCLES = 8 here).
module tb_el2_pmu_halt_initiator;
    logic clk = 1'b0;
    logic rst_l = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    el2_pmu_halt_initiator_if bus ();

    el2_pmu_halt_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .rst_l(rst_l),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.cpu_halt_req, bus.cpu_run_req, bus.busy, bus.halted, bus.cmd_done, bus.cmd_rejected, bus.timeout_err};
    endfunction

    task automatic drive(input logic [5:0] s);
        {bus.sw_halt_req, bus.sw_run_req, bus.cpu_halt_ack, bus.cpu_run_ack, bus.cpu_halt_status, bus.cpu_debug_mode} = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(6'b000000);
        #3 rst_l = 1'b0;
        #1;
        if (outs() !== 7'b0000000) begin $display("FAIL reset_async got %b exp %b", outs(), 7'b0000000); n_fail++; end
        n_checks++;
        drive(6'b110000);
        tick();
        tick();
        if (outs() !== 7'b0000000) begin $display("FAIL reset_held got %b exp %b", outs(), 7'b0000000); n_fail++; end
        n_checks++;
        drive(6'b000000);
        rst_l = 1'b1;
        tick();
        if (outs() !== 7'b0000000) begin $display("FAIL reset_release got %b exp %b", outs(), 7'b0000000); n_fail++; end
        n_checks++;
    endtask

    // Halt accepted at cycle 0, ack high cycles 5-6: request high 1-5, cmd_done at cycle 8.
    task automatic test_halt();
        logic [12:0] v [9];
        v = '{
            {6'b100000, 7'b1010000},
            {6'b000000, 7'b1010000},
            {6'b000000, 7'b1010000},
            {6'b000000, 7'b1010000},
            {6'b000000, 7'b1010000},
            {6'b001010, 7'b0010000},
            {6'b001010, 7'b0010000},
            {6'b000010, 7'b0001100},
            {6'b000010, 7'b0001000}
        };
        for (int i = 0; i < 9; i++) begin
            drive(v[i][12:7]);
            tick();
            if (outs() !== v[i][6:0]) begin $display("FAIL halt_c%0d got %b exp %b", i, outs(), v[i][6:0]); n_fail++; end
            n_checks++;
        end
    endtask

    // From HALTED: run request for 3 cycles, ack, drop, cmd_done, back to idle.
    task automatic test_run();
        logic [12:0] v [6];
        v = '{
            {6'b010010, 7'b0110000},
            {6'b000010, 7'b0110000},
            {6'b000010, 7'b0110000},
            {6'b000100, 7'b0010000},
            {6'b000000, 7'b0000100},
            {6'b000000, 7'b0000000}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i][12:7]);
            tick();
            if (outs() !== v[i][6:0]) begin $display("FAIL run_c%0d got %b exp %b", i, outs(), v[i][6:0]); n_fail++; end
            n_checks++;
        end
    endtask

    task automatic test_reject();
        logic [12:0] v [6];
        v = '{
            {6'b100001, 7'b0000010},
            {6'b000001, 7'b0000000},
            {6'b010000, 7'b0000010},
            {6'b000000, 7'b0000000},
            {6'b110001, 7'b0000010},
            {6'b000000, 7'b0000000}
        };
        for (int i = 0; i < 6; i++) begin
            drive(v[i][12:7]);
            tick();
            if (outs() !== v[i][6:0]) begin $display("FAIL reject_c%0d got %b exp %b", i, outs(), v[i][6:0]); n_fail++; end
            n_checks++;
        end
    endtask

    // Simultaneous pulses, busy rejection, and debug mode rising mid-handshake.
    task automatic test_back_to_back();
        logic [12:0] v [11];
        v = '{
            {6'b110000, 7'b1010010},
            {6'b100000, 7'b1010010},
            {6'b000001, 7'b1010000},
            {6'b001010, 7'b0010000},
            {6'b000010, 7'b0001100},
            {6'b110010, 7'b0110010},
            {6'b000011, 7'b0110000},
            {6'b000011, 7'b0110000},
            {6'b000101, 7'b0010000},
            {6'b000000, 7'b0000100},
            {6'b000000, 7'b0000000}
        };
        for (int i = 0; i < 11; i++) begin
            drive(v[i][12:7]);
            tick();
            if (outs() !== v[i][6:0]) begin $display("FAIL b2b_c%0d got %b exp %b", i, outs(), v[i][6:0]); n_fail++; end
            n_checks++;
        end
    endtask

    task automatic test_self_wake();
        logic [12:0] v [9];
        v = '{
            {6'b100000, 7'b1010000},
            {6'b001010, 7'b0010000},
            {6'b000010, 7'b0001100},
            {6'b000010, 7'b0001000},
            {6'b000000, 7'b0000000},
            {6'b100000, 7'b1010000},
            {6'b001010, 7'b0010000},
            {6'b000010, 7'b0001100},
            {6'b000000, 7'b0000000}
        };
        for (int i = 0; i < 9; i++) begin
            drive(v[i][12:7]);
            tick();
            if (outs() !== v[i][6:0]) begin $display("FAIL wake_c%0d got %b exp %b", i, outs(), v[i][6:0]); n_fail++; end
            n_checks++;
        end
    endtask

    task automatic test_timeout();
        logic [12:0] q [$];
`ifdef EL2_PMU_HALT_TIMEOUT_EN
        q.push_back({6'b100000, 7'b1010000});
        for (int i = 1; i < 8; i++) q.push_back({6'b000000, 7'b1010000});
        q.push_back({6'b000000, 7'b0000001});
        q.push_back({6'b000000, 7'b0000001});
        q.push_back({6'b100000, 7'b1010000});
`else
        q.push_back({6'b100000, 7'b1010000});
        for (int i = 0; i < 20; i++) q.push_back({6'b000000, 7'b1010000});
`endif
        q.push_back({6'b001010, 7'b0010000});
        q.push_back({6'b000010, 7'b0001100});
        q.push_back({6'b000000, 7'b0000000});
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i][12:7]);
            tick();
            if (outs() !== q[i][6:0]) begin $display("FAIL timeout_c%0d got %b exp %b", i, outs(), q[i][6:0]); n_fail++; end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid();
        logic [12:0] v [4];
        v = '{
            {6'b100000, 7'b1010000},
            {6'b001010, 7'b0010000},
            {6'b000010, 7'b0001100},
            {6'b010010, 7'b0110000}
        };
        for (int i = 0; i < 4; i++) begin
            drive(v[i][12:7]);
            tick();
            if (outs() !== v[i][6:0]) begin $display("FAIL rstmid_c%0d got %b exp %b", i, outs(), v[i][6:0]); n_fail++; end
            n_checks++;
        end
        #2 rst_l = 1'b0;
        #1;
        if (outs() !== 7'b0000000) begin $display("FAIL rstmid_async got %b exp %b", outs(), 7'b0000000); n_fail++; end
        n_checks++;
        tick();
        rst_l = 1'b1;
        drive(6'b000100);
        tick();
        if (outs() !== 7'b0000000) begin $display("FAIL rstmid_after got %b exp %b", outs(), 7'b0000000); n_fail++; end
        n_checks++;
        drive(6'b000000);
        tick();
        if (outs() !== 7'b0000000) begin $display("FAIL rstmid_quiet got %b exp %b", outs(), 7'b0000000); n_fail++; end
        n_checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_halt();
        test_run();
        test_reject();
        test_back_to_back();
        test_self_wake();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
